// File: rtl/buzzer_arbiter.sv
// rtl/buzzer_arbiter.sv - fixed-priority owner arbiter for the shared buzzer with hold time and silence gap
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req[2:0]                   requests, bit 2 highest priority
//   note0..2 / pitch0..2       per-requester note (0 = rest) and octave codes
//   gnt[2:0]                   one-hot grant, zero outside PLAY
//   note_out / pitch_out       registered tone selection to the buzzer
//   busy                       high in PLAY or GAP
//   owner[1:0]                 current owner index, 0 when nothing granted
module buzzer_arbiter #(
    parameter int GAP_CYCLES = 250_000,
    parameter int MIN_HOLD   = 1_250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [3:0] note0,
    input  logic [3:0] note1,
    input  logic [3:0] note2,
    input  logic [1:0] pitch0,
    input  logic [1:0] pitch1,
    input  logic [1:0] pitch2,
    output logic [2:0] gnt,
    output logic [3:0] note_out,
    output logic [1:0] pitch_out,
    output logic       busy,
    output logic [1:0] owner
);

    localparam int HOLD_W = ($clog2(MIN_HOLD + 1) < 1) ? 1 : $clog2(MIN_HOLD + 1);
    localparam int GAP_W  = ($clog2(GAP_CYCLES) < 1) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [HOLD_W-1:0] hold_cnt, hold_d;
    logic [GAP_W-1:0]  gap_cnt, gap_d;
    logic [2:0]        gnt_d;
    logic [1:0]        owner_d;
    logic [3:0]        note_d;
    logic [1:0]        pitch_d;

    logic [1:0] win_idx;
    logic [3:0] win_note, own_note;
    logic [1:0] win_pitch, own_pitch;
    logic       own_req, higher_req;

    // Highest set request bit wins.
    always_comb begin
        win_idx = 2'd0;
        if (req[2])      win_idx = 2'd2;
        else if (req[1]) win_idx = 2'd1;
    end

    always_comb begin
        win_note  = note0;
        win_pitch = pitch0;
        case (win_idx)
            2'd1:    begin win_note = note1; win_pitch = pitch1; end
            2'd2:    begin win_note = note2; win_pitch = pitch2; end
            default: begin win_note = note0; win_pitch = pitch0; end
        endcase
    end

    // Owner's own inputs, plus whether anything above the owner is asking.
    always_comb begin
        own_note   = note0;
        own_pitch  = pitch0;
        own_req    = req[0];
        higher_req = |req[2:1];
        case (owner)
            2'd1: begin
                own_note   = note1;
                own_pitch  = pitch1;
                own_req    = req[1];
                higher_req = req[2];
            end
            2'd2: begin
                own_note   = note2;
                own_pitch  = pitch2;
                own_req    = req[2];
                higher_req = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state;
        hold_d  = hold_cnt;
        gap_d   = gap_cnt;
        gnt_d   = 3'b000;
        owner_d = 2'd0;
        note_d  = 4'd0;
        pitch_d = 2'd0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_PLAY;
                    owner_d = win_idx;
                    gnt_d   = 3'b001 << win_idx;
                    note_d  = win_note;
                    pitch_d = win_pitch;
                    hold_d  = '0;
                end
            end
            ST_PLAY: begin
                // Release wins regardless of hold; preempt only once the hold has saturated.
                if (!own_req || (higher_req && hold_cnt == HOLD_MAX)) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end else begin
                    owner_d = owner;
                    gnt_d   = gnt;
                    note_d  = own_note;
                    pitch_d = own_pitch;
                    if (hold_cnt != HOLD_MAX) hold_d = hold_cnt + HOLD_W'(1);
                end
            end
            ST_GAP: begin
                // Requests are only looked at on the last gap edge.
                if (gap_cnt == GAP_LAST) begin
                    if (|req) begin
                        state_d = ST_PLAY;
                        owner_d = win_idx;
                        gnt_d   = 3'b001 << win_idx;
                        note_d  = win_note;
                        pitch_d = win_pitch;
                        hold_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_cnt + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            gnt       <= 3'b000;
            owner     <= 2'd0;
            note_out  <= 4'd0;
            pitch_out <= 2'd0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            hold_cnt  <= hold_d;
            gap_cnt   <= gap_d;
            gnt       <= gnt_d;
            owner     <= owner_d;
            note_out  <= note_d;
            pitch_out <= pitch_d;
            busy      <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb/tb_buzzer_arbiter.sv - scoreboard bench for buzzer_arbiter
module tb_buzzer_arbiter;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [3:0] note0, note1, note2;
    logic [1:0] pitch0, pitch1, pitch2;
    logic [2:0] gnt;
    logic [3:0] note_out;
    logic [1:0] pitch_out;
    logic       busy;
    logic [1:0] owner;

    buzzer_arbiter #(.GAP_CYCLES(4), .MIN_HOLD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .note0     (note0),
        .note1     (note1),
        .note2     (note2),
        .pitch0    (pitch0),
        .pitch1    (pitch1),
        .pitch2    (pitch2),
        .gnt       (gnt),
        .note_out  (note_out),
        .pitch_out (pitch_out),
        .busy      (busy),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [2:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic [3:0] note;
        logic [1:0] pitch;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] g, input logic [1:0] o,
                            input logic b, input logic [3:0] n, input logic [1:0] p);
        exp_t e;
        e.tag = tag; e.gnt = g; e.owner = o; e.busy = b; e.note = n; e.pitch = p;
        exp_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, ".gnt"},   {5'd0, gnt},       {5'd0, e.gnt});
            chk({e.tag, ".owner"}, {6'd0, owner},     {6'd0, e.owner});
            chk({e.tag, ".busy"},  {7'd0, busy},      {7'd0, e.busy});
            chk({e.tag, ".note"},  {4'd0, note_out},  {4'd0, e.note});
            chk({e.tag, ".pitch"}, {6'd0, pitch_out}, {6'd0, e.pitch});
        end
    endtask

    // Expect the given outputs right now, without a clock edge.
    task automatic sample(input string tag, input logic [2:0] g, input logic [1:0] o,
                          input logic b, input logic [3:0] n, input logic [1:0] p);
        push_exp(tag, g, o, b, n, p);
        compare_out();
    endtask

    // Expect the given outputs after the next rising edge.
    task automatic cyc(input string tag, input logic [2:0] g, input logic [1:0] o,
                       input logic b, input logic [3:0] n, input logic [1:0] p);
        push_exp(tag, g, o, b, n, p);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        note0 = 4'd0; note1 = 4'd0; note2 = 4'd0;
        pitch0 = 2'd0; pitch1 = 2'd0; pitch2 = 2'd0;
        #1;
        sample("reset", 3'b000, 2'd0, 1'b0, 4'd0, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("idle", 3'b000, 2'd0, 1'b0, 4'd0, 2'd0);

        // Single request, then release straight into a 4-cycle gap.
        req = 3'b001; note0 = 4'd6; pitch0 = 2'd2;
        cyc("s1_grant", 3'b001, 2'd0, 1'b1, 4'd6, 2'd2);
        req = 3'b000;
        cyc("s1_release", 3'b000, 2'd0, 1'b1, 4'd0, 2'd0);
        for (int i = 0; i < 3; i++) cyc("s1_gap", 3'b000, 2'd0, 1'b1, 4'd0, 2'd0);
        cyc("s1_idle", 3'b000, 2'd0, 1'b0, 4'd0, 2'd0);

        // Preemption only after the hold time has saturated.
        req = 3'b001; note0 = 4'd3; pitch0 = 2'd1; note2 = 4'd12; pitch2 = 2'd3;
        cyc("s2_grant", 3'b001, 2'd0, 1'b1, 4'd3, 2'd1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) req = 3'b101;
            cyc("s2_hold", 3'b001, 2'd0, 1'b1, 4'd3, 2'd1);
        end
        cyc("s2_preempt", 3'b000, 2'd0, 1'b1, 4'd0, 2'd0);
        for (int i = 0; i < 3; i++) cyc("s2_gap", 3'b000, 2'd0, 1'b1, 4'd0, 2'd0);
        cyc("s2_newowner", 3'b100, 2'd2, 1'b1, 4'd12, 2'd3);

        // Lower-priority requests never preempt.
        req = 3'b111;
        for (int i = 0; i < 50; i++) cyc("s3_nopreempt", 3'b100, 2'd2, 1'b1, 4'd12, 2'd3);

        // Back to IDLE, then all three request at once.
        req = 3'b000;
        for (int i = 0; i < 4; i++) cyc("s4_drain", 3'b000, 2'd0, 1'b1, 4'd0, 2'd0);
        cyc("s4_idle", 3'b000, 2'd0, 1'b0, 4'd0, 2'd0);
        req = 3'b111; note1 = 4'd5; pitch1 = 2'd0;
        cyc("s4_grant", 3'b100, 2'd2, 1'b1, 4'd12, 2'd3);
        cyc("s4_play", 3'b100, 2'd2, 1'b1, 4'd12, 2'd3);
        req = 3'b011;
        cyc("s4_release", 3'b000, 2'd0, 1'b1, 4'd0, 2'd0);
        req = 3'b001;
        cyc("s4_gap1", 3'b000, 2'd0, 1'b1, 4'd0, 2'd0);
        req = 3'b000;
        cyc("s4_gap2", 3'b000, 2'd0, 1'b1, 4'd0, 2'd0);
        req = 3'b001;
        cyc("s4_gap3", 3'b000, 2'd0, 1'b1, 4'd0, 2'd0);
        req = 3'b011;
        cyc("s4_regrant", 3'b010, 2'd1, 1'b1, 4'd5, 2'd0);

        // Pass-through of owner 1's note including rests.
        req = 3'b010;
        note1 = 4'd0;
        cyc("s6_rest", 3'b010, 2'd1, 1'b1, 4'd0, 2'd0);
        note1 = 4'd9;
        cyc("s6_note9", 3'b010, 2'd1, 1'b1, 4'd9, 2'd0);
        note1 = 4'd11; pitch1 = 2'd2;
        cyc("s6_note11", 3'b010, 2'd1, 1'b1, 4'd11, 2'd2);

        // Asynchronous reset mid-tone.
        #2;
        rst_n = 1'b0;
        #1;
        sample("s5_async_rst", 3'b000, 2'd0, 1'b0, 4'd0, 2'd0);
        @(posedge clk); #1;
        sample("s5_rst_held", 3'b000, 2'd0, 1'b0, 4'd0, 2'd0);
        rst_n = 1'b1;
        req = 3'b010; note1 = 4'd7; pitch1 = 2'd1;
        cyc("s5_first_edge", 3'b010, 2'd1, 1'b1, 4'd7, 2'd1);

        if (exp_q.size() != 0) chk("queue_leftover", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
